// File: rtl/jam_lane_scheduler.sv
// jam_lane_scheduler
//   Consumer side of the jam-counter interface. Watches per-lane jam flags,
//   enables the jam counter while any lane is jammed, and hands the green
//   phase round-robin among jammed lanes, one counter period per turn.
//
//   Optional feature macro: JAM_ALL_RED_EN
//     defined   : a lane change passes through an all-red CLEAR phase of
//                 ALL_RED_CYCLES cycles (green_lane = 0) before the new green.
//     undefined : lane change is immediate, green to green.
//
// Parameters
//   N_LANES         number of lanes (>= 2)
//   ALL_RED_CYCLES  all-red clearance length in cycles (1..7), CLEAR only
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   lane_jam        per-lane jam level flags
//   jam_start       counter pulse: period started
//   jam_rotation    counter pulse: 15-cycle period elapsed
//   jam_counter_en  enables the jam counter (counter clears when low)
//   green_lane      one-hot green grant, all-zero = no jam green
//   cur_lane        index of the granted/selected lane
//   jam_active      high whenever the scheduler is not idle
//   rot_count       completed rotations since the last IDLE exit (wraps)
module jam_lane_scheduler #(
   parameter int N_LANES        = 4,
   parameter int ALL_RED_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_LANES-1:0]         lane_jam,
   input  logic                       jam_start,
   input  logic                       jam_rotation,
   output logic                       jam_counter_en,
   output logic [N_LANES-1:0]         green_lane,
   output logic [$clog2(N_LANES)-1:0] cur_lane,
   output logic                       jam_active,
   output logic [7:0]                 rot_count
);

   localparam int LW = $clog2(N_LANES);

`ifdef JAM_ALL_RED_EN
   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SERVE, ST_CLEAR} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_SERVE} state_t;
`endif

   state_t              r_state, w_state;
   logic                r_en, w_en;
   logic [N_LANES-1:0]  r_green, w_green;
   logic [LW-1:0]       r_cur, w_cur;
   logic [LW-1:0]       r_ptr, w_ptr;
   logic [7:0]          r_rot, w_rot;
   logic [LW-1:0]       w_sel_ptr;
   logic [LW-1:0]       w_sel_next;
   logic [LW-1:0]       w_cur_inc;
   logic                w_any;
`ifdef JAM_ALL_RED_EN
   // Remaining all-red cycles after the current one.
   logic [2:0]          r_clr, w_clr;
`endif

   function automatic logic [LW-1:0] f_inc(input logic [LW-1:0] idx);
      int v;
      v = (int'(idx) + 1) % N_LANES;
      return LW'(v);
   endfunction

   // First jammed lane searching from 'start' upward with wrap. Scanning
   // downward and overwriting leaves the lowest offset as the winner.
   // With no lane jammed the result is 'start' (callers check w_any).
   function automatic logic [LW-1:0] f_first_jam(input logic [N_LANES-1:0] jam,
                                                 input logic [LW-1:0]      start);
      logic [LW-1:0] sel;
      int            idx;
      sel = start;
      for (int k = N_LANES - 1; k >= 0; k--) begin
         idx = (int'(start) + k) % N_LANES;
         if (jam[LW'(idx)]) sel = LW'(idx);
      end
      return sel;
   endfunction

   function automatic logic [N_LANES-1:0] f_onehot(input logic [LW-1:0] idx);
      logic [N_LANES-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   assign w_any      = |lane_jam;
   assign w_cur_inc  = f_inc(r_cur);
   assign w_sel_ptr  = f_first_jam(lane_jam, r_ptr);
   // Search strictly after cur_lane; cur_lane itself is the last candidate.
   assign w_sel_next = f_first_jam(lane_jam, w_cur_inc);

   always_comb begin
      w_state = r_state;
      w_en    = r_en;
      w_green = r_green;
      w_cur   = r_cur;
      w_ptr   = r_ptr;
      w_rot   = r_rot;
`ifdef JAM_ALL_RED_EN
      w_clr   = r_clr;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state = ST_ARM;
               w_cur   = w_sel_ptr;
               w_en    = 1'b1;
               w_rot   = 8'd0;
            end
         end
         ST_ARM: begin
            // A start pulse wins over a same-cycle drop of all jam flags:
            // once the period has begun the turn is served to the end.
            if (jam_start) begin
               w_state = ST_SERVE;
               w_green = f_onehot(r_cur);
            end else if (!w_any) begin
               w_state = ST_IDLE;
               w_en    = 1'b0;
            end
         end
         ST_SERVE: begin
            if (jam_rotation) begin
               w_rot = r_rot + 8'd1;
               if (!w_any) begin
                  w_state = ST_IDLE;
                  w_en    = 1'b0;
                  w_green = '0;
                  w_ptr   = w_cur_inc;
               end else if (w_sel_next != r_cur) begin
                  w_cur = w_sel_next;
`ifdef JAM_ALL_RED_EN
                  w_state = ST_CLEAR;
                  w_green = '0;
                  w_clr   = 3'(ALL_RED_CYCLES - 1);
`else
                  w_green = f_onehot(w_sel_next);
`endif
               end
            end
         end
`ifdef JAM_ALL_RED_EN
         ST_CLEAR: begin
            // The counter keeps running; the new lane gets what is left.
            if (r_clr == 3'd0) begin
               w_state = ST_SERVE;
               w_green = f_onehot(r_cur);
            end else begin
               w_clr = r_clr - 3'd1;
            end
         end
`endif
         default: begin
            w_state = ST_IDLE;
            w_en    = 1'b0;
            w_green = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_en    <= 1'b0;
         r_green <= '0;
         r_cur   <= '0;
         r_ptr   <= '0;
         r_rot   <= 8'd0;
`ifdef JAM_ALL_RED_EN
         r_clr   <= 3'd0;
`endif
      end else begin
         r_state <= w_state;
         r_en    <= w_en;
         r_green <= w_green;
         r_cur   <= w_cur;
         r_ptr   <= w_ptr;
         r_rot   <= w_rot;
`ifdef JAM_ALL_RED_EN
         r_clr   <= w_clr;
`endif
      end
   end

   assign jam_counter_en = r_en;
   assign green_lane     = r_green;
   assign cur_lane       = r_cur;
   assign jam_active     = (r_state != ST_IDLE);
   assign rot_count      = r_rot;

endmodule

// File: tb/tb_jam_lane_scheduler.sv
// Testbench for jam_lane_scheduler: emulates the jam counter, drives
// directed and random lane_jam patterns, and checks every cycle against a
// behavioural model of the scheduling rules.
module tb_jam_lane_scheduler;

   localparam int N = 4;
   localparam int A = 2;
`ifdef JAM_ALL_RED_EN
   localparam bit ALLRED = 1'b1;
   localparam int SETTLE = A;
`else
   localparam bit ALLRED = 1'b0;
   localparam int SETTLE = 0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N-1:0]         lane_jam = '0;
   logic                 jam_start = 1'b0;
   logic                 jam_rotation = 1'b0;
   logic                 jam_counter_en;
   logic [N-1:0]         green_lane;
   logic [$clog2(N)-1:0] cur_lane;
   logic                 jam_active;
   logic [7:0]           rot_count;

   int n_cmp  = 0;
   int n_fail = 0;

   // counter emulation state (stimulus process only)
   int age        = 0;
   bit hold_start = 1'b0;
   bit spur       = 1'b0;

   // behavioural model: mode 0 idle, 1 armed, 2 serving, 3 all-red
   int m_mode = 0, m_cur = 0, m_ptr = 0, m_rot = 0, m_clr = 0;

   always #5 clk = ~clk;

   jam_lane_scheduler #(.N_LANES(N), .ALL_RED_CYCLES(A)) dut (
      .clk            (clk),
      .rst            (rst),
      .lane_jam       (lane_jam),
      .jam_start      (jam_start),
      .jam_rotation   (jam_rotation),
      .jam_counter_en (jam_counter_en),
      .green_lane     (green_lane),
      .cur_lane       (cur_lane),
      .jam_active     (jam_active),
      .rot_count      (rot_count)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int first_jam(input logic [N-1:0] jam, input int s);
      for (int k = 0; k < N; k++)
         if (jam[(s + k) % N]) return (s + k) % N;
      return -1;
   endfunction

   task model_step(input logic [N-1:0] jam, input logic st, input logic rot);
      int nxt;
      case (m_mode)
         0: if (jam != 0) begin
               m_mode = 1; m_cur = first_jam(jam, m_ptr); m_rot = 0;
            end
         1: if (st) m_mode = 2;
            else if (jam == 0) m_mode = 0;
         2: if (rot) begin
               m_rot = (m_rot + 1) % 256;
               nxt   = first_jam(jam, (m_cur + 1) % N);
               if (nxt < 0) begin
                  m_mode = 0; m_ptr = (m_cur + 1) % N;
               end else if (nxt != m_cur) begin
                  m_cur = nxt;
                  if (ALLRED) begin m_mode = 3; m_clr = A; end
               end
            end
         default: begin
            m_clr--;
            if (m_clr == 0) m_mode = 2;
         end
      endcase
   endtask

   // model update at each edge, compare just after it
   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_cur = 0; m_ptr = 0; m_rot = 0; m_clr = 0;
      end else begin
         model_step(lane_jam, jam_start, jam_rotation);
      end
      #1;
      chk("m_en",     32'(jam_counter_en), 32'(m_mode != 0));
      chk("m_green",  32'(green_lane),     (m_mode == 2) ? (32'd1 << m_cur) : 32'd0);
      chk("m_cur",    32'(cur_lane),       32'(m_cur));
      chk("m_active", 32'(jam_active),     32'(m_mode != 0));
      chk("m_rot",    32'(rot_count),      32'(m_rot));
   end

   // One clock: wait for the edge, then drive next-cycle inputs including
   // the emulated counter's pulses.
   task automatic cycle(input logic [N-1:0] jam);
      @(posedge clk);
      #2;
      if (jam_counter_en) age++; else age = 0;
      lane_jam     = jam;
      jam_start    = (age == 1) && !hold_start;
      jam_rotation = (age > 1) && ((age - 1) % 15 == 0);
      if (spur && !jam_counter_en) begin
         jam_start    = ($urandom_range(0, 3) == 0);
         jam_rotation = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic do_reset(input logic [N-1:0] jam);
      rst = 1'b1;
      repeat (3) begin
         cycle(jam);
         chk("rst_en",     32'(jam_counter_en), 32'd0);
         chk("rst_green",  32'(green_lane),     32'd0);
         chk("rst_cur",    32'(cur_lane),       32'd0);
         chk("rst_active", 32'(jam_active),     32'd0);
         chk("rst_rot",    32'(rot_count),      32'd0);
      end
      rst = 1'b0;
   endtask

   task automatic wait_green(input logic [N-1:0] jam, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         cycle(jam);
         if (green_lane != 0) seen = 1'b1;
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   task automatic wait_rot(input logic [N-1:0] jam, input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cycle(jam);
         if (jam_rotation) seen = 1'b1;
      end
      chk(nm, 32'(seen), 32'd1);
      cycle(jam);
      repeat (SETTLE) cycle(jam);
   endtask

   initial begin
      int rots;
      bit seen;
      logic [N-1:0] rj;

      // reset with lanes 1,2 jammed, then first grant goes to lane 1
      do_reset(4'b0110);
      cycle(4'b0110);
      chk("t1_en_rise",  32'(jam_counter_en), 32'd1);
      chk("t1_no_green", 32'(green_lane),     32'd0);
      cycle(4'b0110);
      chk("t1_green",    32'(green_lane),     32'h2);
      chk("t1_cur",      32'(cur_lane),       32'd1);

      // served lane drops mid-period: turn runs to the rotation, then IDLE
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(4'b0000);
         chk("t4_hold_green", 32'(green_lane),     32'h2);
         chk("t4_hold_en",    32'(jam_counter_en), 32'd1);
         if (jam_rotation) seen = 1'b1;
      end
      chk("t4_rot_seen", 32'(seen), 32'd1);
      cycle(4'b0000);
      chk("t4_idle_en",    32'(jam_counter_en), 32'd0);
      chk("t4_idle_green", 32'(green_lane),     32'd0);
      chk("t4_idle_rot",   32'(rot_count),      32'd1);
      cycle(4'b0101);
      cycle(4'b0101);
      chk("t4_ptr_sel",    32'(cur_lane),       32'd2);

      // steady 1011 from ptr 0: lanes 0,1,3,0 then rot_count 4
      do_reset(4'b0000);
      wait_green(4'b1011, "t2_start");
      chk("t2_g0", 32'(green_lane), 32'h1);
      wait_rot(4'b1011, "t2_r1");
      chk("t2_g1", 32'(green_lane), 32'h2);
      wait_rot(4'b1011, "t2_r2");
      chk("t2_g2", 32'(green_lane), 32'h8);
      wait_rot(4'b1011, "t2_r3");
      chk("t2_g3", 32'(green_lane), 32'h1);
      wait_rot(4'b1011, "t2_r4");
      chk("t2_rot4", 32'(rot_count), 32'd4);

      // single jammed lane 2: green never drops across 3 rotations
      do_reset(4'b0000);
      wait_green(4'b0100, "t3_start");
      rots = 0;
      for (int i = 0; i < 60 && rots < 3; i++) begin
         cycle(4'b0100);
         chk("t3_green", 32'(green_lane),     32'h4);
         chk("t3_en",    32'(jam_counter_en), 32'd1);
         if (jam_rotation) rots++;
      end
      cycle(4'b0100);
      chk("t3_green_end", 32'(green_lane), 32'h4);
      chk("t3_rots", 32'(rots), 32'd3);

      // jam drops in ARM before jam_start: back to IDLE, no green
      do_reset(4'b0000);
      hold_start = 1'b1;
      cycle(4'b0001);
      cycle(4'b0000);
      chk("t5_arm_en", 32'(jam_counter_en), 32'd1);
      cycle(4'b0000);
      chk("t5_idle_en",    32'(jam_counter_en), 32'd0);
      chk("t5_idle_green", 32'(green_lane),     32'd0);
      cycle(4'b0000);
      chk("t5_still_idle", 32'(jam_active),     32'd0);
      hold_start = 1'b0;

`ifdef JAM_ALL_RED_EN
      // lanes 0 and 3: exactly A all-red cycles on the lane change
      do_reset(4'b0000);
      wait_green(4'b1001, "t6_start");
      chk("t6_g0", 32'(green_lane), 32'h1);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle(4'b1001);
         if (jam_rotation) seen = 1'b1;
      end
      chk("t6_rot_seen", 32'(seen), 32'd1);
      cycle(4'b1001);
      chk("t6_red1", 32'(green_lane),     32'd0);
      chk("t6_en1",  32'(jam_counter_en), 32'd1);
      cycle(4'b1001);
      chk("t6_red2", 32'(green_lane),     32'd0);
      cycle(4'b1001);
      chk("t6_g3",   32'(green_lane),     32'h8);
`endif

      // random traffic with spurious pulses while idle and rare resets
      spur = 1'b1;
      rj   = '0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0)
            rj = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         rst = ($urandom_range(0, 399) == 0);
         cycle(rj);
      end
      rst  = 1'b0;
      spur = 1'b0;
      repeat (3) cycle(4'b0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/jam_lane_scheduler.md
# jam_lane_scheduler

Lane scheduler on the consumer side of the jam-counter interface in the traffic controller. It watches per-lane jam sensors and drives `jam_counter_en`. It consumes the counter's `jam_start` and `jam_rotation` pulses and hands the green phase round-robin among jammed lanes, one counter period per turn. It sits between the lane sensor inputs and the light driver, in parallel with the normal-cycle controller.

## Interface
- `N_LANES`, 4: number of lanes; ≥2.
- `ALL_RED_CYCLES`, 2: all-red clearance length in cycles (used only with `JAM_ALL_RED_EN`); 1–7.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `lane_jam`  in  N_LANES  per-lane jam flag, level, synchronous to `clk`.
- `jam_start`  in  1  single-cycle pulse from counter: period started.
- `jam_rotation`  in  1  single-cycle pulse from counter: 15-cycle period elapsed.
- `jam_counter_en`  out  1  enables jam counter; counter clears when low.
- `green_lane`  out  N_LANES  one-hot green grant; all-zero = no jam green.
- `cur_lane`  out  $clog2(N_LANES)  index of granted/selected lane.
- `jam_active`  out  1  high in any state except IDLE.
- `rot_count`  out  8  completed rotations since last IDLE exit, wraps at 255→0.

## Operation
- States: IDLE, ARM, SERVE, CLEAR (CLEAR exists only with `JAM_ALL_RED_EN`).
- Priority pointer `ptr` selects the search start lane. Selection = first lane with `lane_jam` set at index ptr, ptr+1, … wrapping modulo N_LANES.
- IDLE:
  - `jam_counter_en`=0, `green_lane`=0.
  - When `lane_jam`≠0 → ARM; `cur_lane` ← selection from `ptr`; `jam_counter_en`←1; `rot_count`←0.
- ARM:
  - Enable held high, green still 0.
  - On `jam_start` → SERVE, `green_lane` ← onehot(`cur_lane`).
  - If `lane_jam`==0 before `jam_start` → IDLE, enable dropped.
- SERVE, on `jam_rotation`:
  - `rot_count`+1.
  - Next lane = first jammed lane strictly after `cur_lane`, wrapping; `cur_lane` itself is the last candidate.
  - None jammed → IDLE; enable and green 0; `ptr` ← cur_lane+1 mod N_LANES.
  - Next == `cur_lane` → stay in SERVE; green unchanged, no glitch.
  - Next ≠ `cur_lane` → green switches directly to new lane (or CLEAR if enabled).
- `lane_jam` deasserting on the served lane mid-period does not cut the turn; service always lasts to `jam_rotation`.
- `jam_rotation` or `jam_start` arriving in an unexpected state (IDLE, or `jam_rotation` in ARM) is ignored.
- `jam_rotation` and a change of `lane_jam` in the same cycle: the selection uses the `lane_jam` value sampled that cycle.

## Timing
- All outputs are registered.
- Reset values: `jam_counter_en`=0, `green_lane`=0, `cur_lane`=0, `jam_active`=0, `rot_count`=0, `ptr`=0, state IDLE.
- `rst` overrides every event in the same cycle.
- Latencies:
  - `lane_jam` rise → `jam_counter_en` high: 1 cycle.
  - `jam_start` → green: 1 cycle.
  - `jam_rotation` → new green or IDLE: 1 cycle.
- Counter contract:
  - `jam_start` arrives 1 cycle after enable rises.
  - `jam_rotation` arrives every 15 cycles while enabled.
  - Enable stays high continuously across rotations; it is never pulsed between lanes.

## Configuration
- `JAM_ALL_RED_EN` defined:
  - A lane change goes SERVE → CLEAR. `green_lane`=0 for exactly `ALL_RED_CYCLES` cycles, then SERVE with the new lane.
  - The counter keeps running, so the effective green is 15−`ALL_RED_CYCLES` cycles.
  - `jam_rotation` during CLEAR is ignored.
  - If `lane_jam` goes to 0 during CLEAR, the new lane is still served for the rest of the period.
- `JAM_ALL_RED_EN` undefined: no CLEAR state; lane change is immediate, green to green.

## Test plan
- Reset with `lane_jam`=4'b0110 held → all outputs 0 while `rst`=1. After release: enable at +1, `jam_start` → `green_lane`=4'b0010, `cur_lane`=1.
- `lane_jam`=4'b1011 steady, 4 rotations → green sequence lane 0,1,3,0; `rot_count`=4.
- Single jammed lane 2 across 3 rotations → `green_lane` stays 4'b0100, no all-zero cycle, enable never drops.
- Lane 1 serving, `lane_jam`→0 mid-period → green held until `jam_rotation`, then IDLE, enable 0 next cycle, `ptr`=2.
- `lane_jam` 0001→0000 in ARM before `jam_start` → IDLE, enable 0, green never asserted.
- With `JAM_ALL_RED_EN`, `ALL_RED_CYCLES`=2, lanes 0 and 3 jammed → on rotation `green_lane`=0 for exactly 2 cycles, then 4'b1000.
